// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Main sequencer of the multicycle ARMv4 datapath. Decodes the latched
// instruction, evaluates its condition against an internal NZCV register and
// walks the datapath through fetch/decode/execute/memory/writeback.
//
// Ports:
//   CLK, Reset     - clock; synchronous active-high reset
//   Instr[31:12]   - instruction register (cond, op, funct, Rd)
//   ALUFlags[3:0]  - {N,Z,C,V} from the ALU this cycle (only feeds the flags reg)
//   IRWrite        - load instruction register
//   AdrSrc         - memory address: 0 = PC, 1 = ALUOut
//   ALUSrcA        - 0 = reg A, 1 = PC
//   ALUSrcB[1:0]   - 00 = reg B, 01 = ExtImm, 10 = constant 4
//   ResultSrc[1:0] - 00 = ALUOut, 01 = mem data, 10 = ALU direct
//   ImmSrc[1:0]    - immediate extension format (= op)
//   RegSrc[1:0]    - register-read address selects
//   ALUControl[3:0]- 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR
//   PCWrite, RegWrite, MemWrite - datapath write enables
//   State[3:0]     - current state for debug
module multicycle_control_fsm (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:12] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  ALUControl,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;

    state_t     state, next_state;
    logic [3:0] flags;                 // {N,Z,C,V}

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign cmd       = funct[4:1];
    assign unused_rn = ^Instr[19:16];

    // Data-processing command decode
    logic [3:0] alu_cmd;
    logic       cmd_wb;      // ADD/SUB/AND/ORR: result goes through ALUWB
    logic       cmd_flags;   // commands allowed to touch the flags register
    logic       cmd_arith;   // commands that also update C and V

    always_comb begin
        alu_cmd   = ALU_ADD;
        cmd_wb    = 1'b0;
        cmd_flags = 1'b0;
        cmd_arith = 1'b0;
        case (cmd)
            4'b0100: begin alu_cmd = ALU_ADD; cmd_wb = 1'b1; cmd_flags = 1'b1; cmd_arith = 1'b1; end
            4'b0010: begin alu_cmd = ALU_SUB; cmd_wb = 1'b1; cmd_flags = 1'b1; cmd_arith = 1'b1; end
            4'b0000: begin alu_cmd = ALU_AND; cmd_wb = 1'b1; cmd_flags = 1'b1; end
            4'b1100: begin alu_cmd = ALU_ORR; cmd_wb = 1'b1; cmd_flags = 1'b1; end
            4'b1010: begin alu_cmd = ALU_SUB; cmd_flags = 1'b1; cmd_arith = 1'b1; end
            default: ;
        endcase
    end

    // Condition check against the registered flags only
    logic n_f, z_f, c_f, v_f, condex;
    assign {n_f, z_f, c_f, v_f} = flags;

    always_comb begin
        case (cond)
            4'b0000: condex = z_f;
            4'b0001: condex = ~z_f;
            4'b0010: condex = c_f;
            4'b0011: condex = ~c_f;
            4'b0100: condex = n_f;
            4'b0101: condex = ~n_f;
            4'b0110: condex = v_f;
            4'b0111: condex = ~v_f;
            4'b1000: condex = c_f & ~z_f;
            4'b1001: condex = ~c_f | z_f;
            4'b1010: condex = (n_f == v_f);
            4'b1011: condex = (n_f != v_f);
            4'b1100: condex = ~z_f & (n_f == v_f);
            4'b1101: condex = z_f | (n_f != v_f);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) state <= FETCH;
        else       state <= next_state;
    end

    // Flags register: written at the end of an execute cycle when S is set
    always_ff @(posedge CLK) begin
        if (Reset) begin
            flags <= '0;
        end else if ((state == EXECUTER || state == EXECUTEI) && funct[0] && cmd_flags) begin
            flags[3:2] <= ALUFlags[3:2];
            if (cmd_arith) flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Next-state logic
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (condex) begin
                    case (op)
                        2'b01:   next_state = MEMADR;
                        2'b00:   next_state = funct[5] ? EXECUTEI : EXECUTER;
                        2'b10:   next_state = BRANCH;
                        default: next_state = FETCH;
                    endcase
                end
            end
            MEMADR:             next_state = funct[0] ? MEMRD : MEMWR;
            MEMRD:              next_state = MEMWB;
            EXECUTER, EXECUTEI: next_state = cmd_wb ? ALUWB : FETCH;
            default:            next_state = FETCH;
        endcase
    end

    // Output logic; write enables are gated by Reset below
    logic irw_raw, pcw_raw, rw_raw, mw_raw;

    always_comb begin
        irw_raw    = 1'b0;
        pcw_raw    = 1'b0;
        rw_raw     = 1'b0;
        mw_raw     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        case (state)
            FETCH: begin
                irw_raw   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcw_raw   = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
            end
            MEMRD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                if (rd == 4'hF) pcw_raw = 1'b1;
                else            rw_raw  = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mw_raw = 1'b1;
            end
            EXECUTER, EXECUTEI: begin
                ALUSrcB    = (state == EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = alu_cmd;
            end
            ALUWB: begin
                if (rd == 4'hF) pcw_raw = 1'b1;
                else            rw_raw  = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pcw_raw   = 1'b1;
            end
            default: ;
        endcase
    end

    assign IRWrite  = irw_raw & ~Reset;
    assign PCWrite  = pcw_raw & ~Reset;
    assign RegWrite = rw_raw  & ~Reset;
    assign MemWrite = mw_raw  & ~Reset;

    assign ImmSrc    = op;
    assign RegSrc[0] = (op == 2'b10);
    assign RegSrc[1] = (op == 2'b01) & ~funct[0];
    assign State     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:12] Instr;
    logic [3:0]  ALUFlags;
    logic        IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0]  ALUControl, State;

    multicycle_control_fsm dut (
        .CLK(CLK), .Reset(Reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .State(State)
    );

    always #5 CLK = ~CLK;

    // exp = {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, PCWrite, RegWrite, MemWrite}
    typedef struct {
        logic        rst;
        logic [19:0] instr;
        logic [3:0]  aluf;
        logic [17:0] exp;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic [19:0] i, input logic [3:0] f,
                       input logic [3:0] s, input logic irw, input logic adr,
                       input logic srca, input logic [1:0] srcb, input logic [1:0] ress,
                       input logic [3:0] aluc, input logic pcw, input logic rw,
                       input logic mw);
        vec_t v;
        v.rst   = r;
        v.instr = i;
        v.aluf  = f;
        v.exp   = {s, irw, adr, srca, srcb, ress, aluc, pcw, rw, mw};
        vq.push_back(v);
    endtask

    task automatic add_fetch(input logic [19:0] i, input logic [3:0] f);
        add(1'b0, i, f, 4'd0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic add_decode(input logic [19:0] i, input logic [3:0] f);
        add(1'b0, i, f, 4'd1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [17:0] got;
        logic [19:0] di [5];
        logic [3:0]  de [5];
        int          n;

        // Reset held: FETCH with all enables low
        add(1'b1, 20'hE0921, 4'h0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 20'hE0921, 4'h0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
        // ADDS R1,R2,R3 with ALUFlags 0110 -> flags 0110
        add_fetch(20'hE0921, 4'b0110);
        add_decode(20'hE0921, 4'b0110);
        add(1'b0, 20'hE0921, 4'b0110, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 20'hE0921, 4'b0110, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0);
        // BCS taken (C=1)
        add_fetch(20'h2A000, 4'h0);
        add_decode(20'h2A000, 4'h0);
        add(1'b0, 20'h2A000, 4'h0, 4'd9, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b0);
        // CMP with ALUFlags 0100 -> flags 0100
        add_fetch(20'hE1520, 4'b0100);
        add_decode(20'hE1520, 4'b0100);
        add(1'b0, 20'hE1520, 4'b0100, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0);
        // BEQ taken
        add_fetch(20'h0A000, 4'h0);
        add_decode(20'h0A000, 4'h0);
        add(1'b0, 20'h0A000, 4'h0, 4'd9, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b0);
        // BCS not taken (C cleared by CMP)
        add_fetch(20'h2A000, 4'h0);
        add_decode(20'h2A000, 4'h0);
        // CMP with ALUFlags 0000 -> flags 0000
        add_fetch(20'hE1520, 4'h0);
        add_decode(20'hE1520, 4'h0);
        add(1'b0, 20'hE1520, 4'h0, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0);
        // EORS (unsupported cmd): ADD, back to FETCH, flags untouched
        add_fetch(20'hE0311, 4'hF);
        add_decode(20'hE0311, 4'hF);
        add(1'b0, 20'hE0311, 4'hF, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        // BEQ not taken although ALUFlags shows Z=1
        add_fetch(20'h0A000, 4'b0100);
        add_decode(20'h0A000, 4'b0100);
        // ANDS with ALUFlags 1111 -> flags 1100 (C,V kept)
        add_fetch(20'hE0111, 4'hF);
        add_decode(20'hE0111, 4'hF);
        add(1'b0, 20'hE0111, 4'hF, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0);
        add(1'b0, 20'hE0111, 4'hF, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0);
        // BCS not taken, BEQ taken
        add_fetch(20'h2A000, 4'h0);
        add_decode(20'h2A000, 4'h0);
        add_fetch(20'h0A000, 4'h0);
        add_decode(20'h0A000, 4'h0);
        add(1'b0, 20'h0A000, 4'h0, 4'd9, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b0);
        // LDR
        add_fetch(20'hE5921, 4'h0);
        add_decode(20'hE5921, 4'h0);
        add(1'b0, 20'hE5921, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 20'hE5921, 4'h0, 4'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 20'hE5921, 4'h0, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0);
        // STR with U=0
        add_fetch(20'hE5021, 4'h0);
        add_decode(20'hE5021, 4'h0);
        add(1'b0, 20'hE5021, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0);
        add(1'b0, 20'hE5021, 4'h0, 4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
        // ADD to PC
        add_fetch(20'hE082F, 4'h0);
        add_decode(20'hE082F, 4'h0);
        add(1'b0, 20'hE082F, 4'h0, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 20'hE082F, 4'h0, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
        // ORR immediate
        add_fetch(20'hE3811, 4'h0);
        add_decode(20'hE3811, 4'h0);
        add(1'b0, 20'hE3811, 4'h0, 4'd7, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0011, 1'b0, 1'b0, 1'b0);
        add(1'b0, 20'hE3811, 4'h0, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0);
        // cond 1111 never; op 11 unsupported
        add_fetch(20'hF0921, 4'h0);
        add_decode(20'hF0921, 4'h0);
        add_fetch(20'hEC000, 4'h0);
        add_decode(20'hEC000, 4'h0);
        // LDR aborted by reset in MEMRD
        add_fetch(20'hE5921, 4'h0);
        add_decode(20'hE5921, 4'h0);
        add(1'b0, 20'hE5921, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 20'hE5921, 4'h0, 4'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        // flags cleared by reset (were 1100): BEQ not taken
        add_fetch(20'h0A000, 4'h0);
        add_decode(20'h0A000, 4'h0);
        // LDR with reset in MEMWB: RegWrite forced low
        add_fetch(20'hE5921, 4'h0);
        add_decode(20'hE5921, 4'h0);
        add(1'b0, 20'hE5921, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 20'hE5921, 4'h0, 4'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 20'hE5921, 4'h0, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
        add_fetch(20'hE0921, 4'h0);

        // Initial reset edge
        Reset    = 1'b1;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        @(posedge CLK);
        #1;

        foreach (vq[k]) begin
            Reset    = vq[k].rst;
            Instr    = vq[k].instr;
            ALUFlags = vq[k].aluf;
            #1;
            got = {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                   PCWrite, RegWrite, MemWrite};
            checks++;
            if (got !== vq[k].exp) begin
                failures++;
                $display("FAIL vec%0d instr=%h got=%b exp=%b", k, vq[k].instr, got, vq[k].exp);
            end
            @(posedge CLK);
            #1;
        end

        // Combinational decode fields, checked while held in reset
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        di[0] = 20'hE0921; de[0] = 4'b0000;
        di[1] = 20'h0A000; de[1] = 4'b1001;
        di[2] = 20'hE5921; de[2] = 4'b0100;
        di[3] = 20'hE5021; de[3] = 4'b0110;
        di[4] = 20'hE3811; de[4] = 4'b0000;
        for (int unsigned i = 0; i < 5; i++) begin
            Instr = di[i];
            #1;
            checks++;
            if ({ImmSrc, RegSrc} !== de[i]) begin
                failures++;
                $display("FAIL decode%0d instr=%h got=%b exp=%b", i, di[i], {ImmSrc, RegSrc}, de[i]);
            end
        end

        // STR latency: MemWrite in the fourth cycle after leaving reset
        Instr = 20'hE5021;
        Reset = 1'b0;
        #1;
        n = 0;
        while (!MemWrite && n < 10) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL str_latency got=%0d edges exp=3", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main sequencer for the multicycle ARMv4 processor variant. It replaces the single-cycle control path: it decodes the latched instruction, evaluates its condition field against an internal NZCV flags register, and steps the shared datapath through fetch, decode, execute, memory and writeback cycles. It drives every multiplexer select and write enable of the datapath: PC, instruction register, register file and data memory.

## Interface
Parameters: none.

Ports:
- `CLK` in 1: system clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Instr` in 20 `[31:12]`: instruction register contents. Fields: cond `[31:28]`, op `[27:26]`, funct `[25:20]`, Rd `[15:12]`.
- `ALUFlags` in 4: `{N,Z,C,V}` from the ALU in the current cycle.
- `IRWrite` out 1: load the instruction register.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALU result register.
- `ALUSrcA` out 1: 0 = register A, 1 = PC.
- `ALUSrcB` out 2: 00 = register B, 01 = ExtImm, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut register, 01 = memory data register, 10 = ALU direct.
- `ImmSrc` out 2: immediate extension format.
- `RegSrc` out 2: register-read address selects.
- `ALUControl` out 4: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR.
- `PCWrite`, `RegWrite`, `MemWrite` out 1: datapath write enables.
- `State` out 4: current state, for debug.

## Operation
- **State encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10–15 return to FETCH on the next edge with all enables low.
- **Combinational decode (valid in every state):**
  - `ImmSrc` = op (00 data-processing imm8, 01 memory imm12, 10 branch imm24).
  - `RegSrc[0]` = (op==10).
  - `RegSrc[1]` = (op==01 & funct[0]==0).
- **FETCH:** IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD, PCWrite=1. Next state: DECODE.
- **DECODE:** ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD; no writes. CondEx is computed from `Instr[31:28]` and the flags register.
  - Condition codes EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL follow ARM semantics; 1111 is never.
  - CondEx=0 → FETCH.
  - Otherwise: op 01 → MEMADR; op 00 with funct[5]=1 → EXECUTEI; op 00 with funct[5]=0 → EXECUTER; op 10 → BRANCH; op 11 → FETCH.
- **MEMADR:** ALUSrcA=0, ALUSrcB=01. ALUControl = ADD if U (funct[3]) = 1, else SUB. Next state: MEMRD if L (funct[0]) = 1, else MEMWR.
- **MEMRD:** AdrSrc=1. Next state: MEMWB.
- **MEMWB:** ResultSrc=01. If Rd==15, PCWrite=1; otherwise RegWrite=1. Next state: FETCH.
- **MEMWR:** AdrSrc=1, MemWrite=1. Next state: FETCH.
- **EXECUTER / EXECUTEI:** ALUSrcA=0; ALUSrcB = 00 (EXECUTER) or 01 (EXECUTEI). cmd = funct[4:1]:
  - 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR; next state ALUWB.
  - 1010 (CMP) → SUB; next state FETCH, no register write.
  - Any other cmd → ADD; next state FETCH; flags not updated.
- **ALUWB:** ResultSrc=00. If Rd==15, PCWrite=1; otherwise RegWrite=1. Next state: FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=01, ResultSrc=10, ALUControl=ADD, PCWrite=1. Next state: FETCH. The L bit is ignored; BL behaves as B.
- **Flags register (4 bits):** written only at the end of EXECUTER/EXECUTEI, and only when S (funct[0]) = 1 for a supported cmd.
  - N and Z are always updated from `ALUFlags`.
  - C and V are updated only for ADD, SUB and CMP.
- **Defaults:** outputs not listed for a state are 0, except ALUControl, which defaults to ADD.

## Timing
- **Reset:** a rising edge with Reset=1 sets State to FETCH and flags to 0000. While Reset=1, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0. The first fetch occurs in the cycle after Reset falls.
- **Reset mid-instruction:** aborts the instruction; no further writes for it.
- **All outputs** are Moore functions of State, `Instr` and the flags register. There is no combinational path from `ALUFlags` to any output.
- **Cycles per instruction:**
  - Condition fails: 2.
  - B: 3.
  - CMP or unsupported op/cmd: 3.
  - STR: 4.
  - Data-processing with writeback: 4.
  - LDR: 5.
- **Hand-off:** `Instr` must be stable from DECODE until the instruction returns to FETCH. IRWrite is asserted only in FETCH.
- **Flag timing:** flags written in EXECUTE are visible to the next instruction's DECODE. They are not visible to the current instruction.

## Test plan
- **Reset:** hold Reset for 2 cycles → State=0 and all enables 0 throughout. After release, FETCH shows IRWrite=1 and PCWrite=1, and ALUSrcB=10.
- **ADD with S set:** Instr=E0921003 (ADDS R1,R2,R3) with ALUFlags=0110 during EXECUTE → sequence 0,1,6,8,0. RegWrite=1 only in ALUWB. Flags become 0110.
- **Conditional branch:** after a CMP that sets Z, run BEQ (0A000002) → states 0,1,9 with PCWrite=1 in BRANCH. Repeat with Z=0 → 0,1,0 with no PCWrite in DECODE.
- **LDR / STR:** LDR E5921004 → 0,1,2,3,4, with ALUControl=ADD in MEMADR and RegWrite in MEMWB. STR E5021004 (U=0) → 0,1,2,5, with ALUControl=SUB and MemWrite=1 in MEMWR.
- **Writeback to PC:** data-processing with Rd=15 (E082F003) → PCWrite=1 and RegWrite=0 in ALUWB.
- **Reset mid-instruction:** assert Reset during MEMRD of an LDR → next State=0, no RegWrite in any cycle, flags 0000.
